// File: rtl/mcu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mcu_mem_arbiter
//
// Shares the MCU's single-port program/data RAM between the instruction-fetch
// port and the load/store data port. Only one RAM transaction is in flight at
// a time. The data port has fixed priority. A streak counter forces a fetch
// grant once STARVE_MAX data grants in a row have been given while a fetch was
// waiting.
//
// Transaction timeline (cycle 0 = IDLE cycle that samples the request):
//   cycle 1            : ACCESS - mem_en pulse, grant pulse to the chosen port
//   cycles 2..1+LAT    : WAIT   - reads only; mem_rdata captured in last one
//   cycle 2+LAT        : IDLE   - rvalid pulse; a new request may be sampled
// Writes go straight from ACCESS back to IDLE (cycle 2).
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   if_req/if_addr              fetch request (read only)
//   if_gnt/if_rvalid/if_rdata   fetch grant pulse, completion pulse, held data
//   d_req/d_we/d_addr/d_wdata   data request (read or write)
//   d_gnt/d_rvalid/d_rdata      data grant pulse, completion pulse, held data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         RAM interface (mem_rdata valid MEM_LAT cycles
//                               after the mem_en cycle)
//   busy                        high whenever the arbiter is not IDLE
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mcu_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
    localparam logic [2:0] WAIT_LAST  = 3'(MEM_LAT - 1);

    state_t state_reg, state_next;

    // Arbitration decision, only ever non-zero in IDLE.
    logic sel_d;
    logic sel_i;
    logic last_wait;

    logic              port_d_reg,    port_d_next;   // 1 = data port owns the transaction
    logic [2:0]        wait_cnt_reg,  wait_cnt_next;
    logic [3:0]        streak_reg,    streak_next;

    logic              if_gnt_reg,    if_gnt_next;
    logic              if_rvalid_reg, if_rvalid_next;
    logic [DATA_W-1:0] if_rdata_reg,  if_rdata_next;
    logic              d_gnt_reg,     d_gnt_next;
    logic              d_rvalid_reg,  d_rvalid_next;
    logic [DATA_W-1:0] d_rdata_reg,   d_rdata_next;
    logic              mem_en_reg,    mem_en_next;
    logic              mem_we_reg,    mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              busy_reg,      busy_next;

    assign last_wait = (wait_cnt_reg == WAIT_LAST);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        sel_d      = 1'b0;
        sel_i      = 1'b0;
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // Data wins unless a waiting fetch has already been passed
                // over STARVE_MAX times in a row.
                if (d_req && !(if_req && streak_reg == STREAK_MAX)) begin
                    sel_d = 1'b1;
                end else if (if_req) begin
                    sel_i = 1'b1;
                end
                if (sel_d || sel_i) begin
                    state_next = ACCESS;
                end
            end
            // mem_we_reg holds the latched write flag during ACCESS.
            ACCESS:  state_next = mem_we_reg ? IDLE : WAIT;
            WAIT:    state_next = last_wait ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Every output is registered, so this process computes the value each
    // output takes in the following cycle.
    always_comb begin
        if_gnt_next    = sel_i;
        d_gnt_next     = sel_d;
        mem_en_next    = sel_d | sel_i;
        mem_we_next    = sel_d & d_we;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        port_d_next    = port_d_reg;
        if_rvalid_next = 1'b0;
        d_rvalid_next  = 1'b0;
        if_rdata_next  = if_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        streak_next    = streak_reg;
        wait_cnt_next  = 3'd0;
        busy_next      = (state_next != IDLE);

        if (sel_d) begin
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
            port_d_next    = 1'b1;
            if (!if_req) begin
                streak_next = 4'd0;
            end else if (streak_reg != STREAK_MAX) begin
                streak_next = streak_reg + 4'd1;
            end
        end else if (sel_i) begin
            // Fetch never writes; mem_wdata keeps its previous value.
            mem_addr_next = if_addr;
            port_d_next   = 1'b0;
            streak_next   = 4'd0;
        end

        if (state_reg == WAIT) begin
            wait_cnt_next = wait_cnt_reg + 3'd1;
            if (last_wait) begin
                if (port_d_reg) begin
                    d_rvalid_next = 1'b1;
                    d_rdata_next  = mem_rdata;
                end else begin
                    if_rvalid_next = 1'b1;
                    if_rdata_next  = mem_rdata;
                end
            end
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            port_d_reg    <= 1'b0;
            wait_cnt_reg  <= 3'd0;
            streak_reg    <= 4'd0;
            if_gnt_reg    <= 1'b0;
            if_rvalid_reg <= 1'b0;
            if_rdata_reg  <= '0;
            d_gnt_reg     <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            d_rdata_reg   <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            port_d_reg    <= port_d_next;
            wait_cnt_reg  <= wait_cnt_next;
            streak_reg    <= streak_next;
            if_gnt_reg    <= if_gnt_next;
            if_rvalid_reg <= if_rvalid_next;
            if_rdata_reg  <= if_rdata_next;
            d_gnt_reg     <= d_gnt_next;
            d_rvalid_reg  <= d_rvalid_next;
            d_rdata_reg   <= d_rdata_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= busy_next;
        end
    end

    assign if_gnt    = if_gnt_reg;
    assign if_rvalid = if_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_gnt     = d_gnt_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule
